// File: rtl/spi_bus_xfer.sv
// SPI-to-RAM transfer engine: takes one latched request per valid/done handshake, waits for a
// bus slot and runs a timed RAM read or write. Optional slot-wait timeout via SPI_XFER_TIMEOUT_EN.
`timescale 1ns/1ps

module spi_bus_xfer #(
    parameter int unsigned ACCESS_CYCLES  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_sys_i,
    input  logic        reset_i,
    input  logic [16:0] spi_addr_i,
    input  logic [7:0]  spi_data_i,
    input  logic        spi_rw_ni,
    input  logic        spi_valid_i,
    output logic [7:0]  spi_data_o,
    output logic        spi_done_o,
    output logic        bus_req_o,
    input  logic        slot_i,
    output logic [16:0] ram_addr_o,
    output logic [7:0]  ram_data_o,
    input  logic [7:0]  ram_data_i,
`ifdef SPI_XFER_TIMEOUT_EN
    output logic        err_o,
`endif
    output logic        ram_oe_no,
    output logic        ram_we_no
);

    if (ACCESS_CYCLES < 3 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("spi_bus_xfer: ACCESS_CYCLES must be >= 3 and TIMEOUT_CYCLES >= 1");
    end

    localparam int CNT_W = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_WE_END = CNT_W'(ACCESS_CYCLES - 2);

`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             rw_q,       rw_d;
    logic             done_q,     done_d;
    logic             bus_req_q,  bus_req_d;
    logic             oe_n_q,     oe_n_d;
    logic             we_n_q,     we_n_d;
    logic [7:0]       rdata_q,    rdata_d;
    logic [16:0]      addr_q,     addr_d;
    logic [7:0]       wdata_q,    wdata_d;
`ifdef SPI_XFER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    logic             err_q,      err_d;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case leaves
        // one unassigned; without these defaults synthesis would infer latches.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        done_d    = done_q;
        bus_req_d = bus_req_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef SPI_XFER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (spi_valid_i && !done_q) begin
                    addr_d    = spi_addr_i;
                    wdata_d   = spi_data_i;
                    rw_d      = spi_rw_ni;
                    bus_req_d = 1'b1;
                    state_d   = ST_WAIT_SLOT;
`ifdef SPI_XFER_TIMEOUT_EN
                    tmo_cnt_d = '0;
                    err_d     = 1'b0;
`endif
                end
            end

            ST_WAIT_SLOT: begin
                if (!spi_valid_i) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (slot_i) begin
                    // Read drives OE from the first access cycle; write waits one setup cycle.
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    oe_n_d    = !rw_q;
                    we_n_d    = 1'b1;
                    state_d   = ST_ACCESS;
`ifdef SPI_XFER_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    bus_req_d = 1'b0;
                    rdata_d   = 8'hFF;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end

            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    oe_n_d = 1'b1;
                    we_n_d = 1'b1;
                    if (rw_q) begin
                        rdata_d = ram_data_i;
                    end
                    if (spi_valid_i) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // WE is low for the cycles after setup and before the final hold cycle.
                    cnt_d  = cnt_q + 1'b1;
                    we_n_d = !(!rw_q && (cnt_q < CNT_WE_END));
                end
            end

            ST_DONE: begin
                if (!spi_valid_i) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            done_q    <= 1'b0;
            bus_req_q <= 1'b0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            rdata_q   <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
`ifdef SPI_XFER_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            done_q    <= done_d;
            bus_req_q <= bus_req_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`ifdef SPI_XFER_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign spi_data_o = rdata_q;
    assign spi_done_o = done_q;
    assign bus_req_o  = bus_req_q;
    assign ram_addr_o = addr_q;
    assign ram_data_o = wdata_q;
    assign ram_oe_no  = oe_n_q;
    assign ram_we_no  = we_n_q;
`ifdef SPI_XFER_TIMEOUT_EN
    assign err_o      = err_q;
`endif

endmodule

// File: tb/tb_spi_bus_xfer.sv
// Bench for spi_bus_xfer: behavioural RAM, a scoreboard of expected transfer results, and
// one task per scenario. Exercises the timeout path when SPI_XFER_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_spi_bus_xfer;

    localparam int AC = 3;
`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
        logic        rw_n;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [16:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_rw_n;
    logic        spi_valid;
    logic [7:0]  spi_data_o;
    logic        spi_done_o;
    logic        bus_req_o;
    logic        slot;
    logic [16:0] ram_addr_o;
    logic [7:0]  ram_data_o;
    logic [7:0]  ram_data_i;
    logic        ram_oe_no;
    logic        ram_we_no;
`ifdef SPI_XFER_TIMEOUT_EN
    logic        err_o;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;
    exp_t sb[$];

    spi_bus_xfer #(
        .ACCESS_CYCLES (AC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_sys_i  (clk),
        .reset_i    (reset),
        .spi_addr_i (spi_addr),
        .spi_data_i (spi_wdata),
        .spi_rw_ni  (spi_rw_n),
        .spi_valid_i(spi_valid),
        .spi_data_o (spi_data_o),
        .spi_done_o (spi_done_o),
        .bus_req_o  (bus_req_o),
        .slot_i     (slot),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i),
`ifdef SPI_XFER_TIMEOUT_EN
        .err_o      (err_o),
`endif
        .ram_oe_no  (ram_oe_no),
        .ram_we_no  (ram_we_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous-read RAM with a preload port owned by the stimulus process.
    logic [7:0]  mem [0:131071];
    logic        pre_en = 1'b0;
    logic [16:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (!ram_we_no) mem[ram_addr_o] <= ram_data_o;
    end

    assign ram_data_i = ram_oe_no ? 8'h00 : mem[ram_addr_o];

    // Strobe monitor, sampled mid-cycle.
    int          oe_lows = 0;
    int          we_lows = 0;
    logic [16:0] we_addr = '0;
    logic [7:0]  we_data = '0;

    always @(negedge clk) begin
        if (!ram_oe_no) oe_lows <= oe_lows + 1;
        if (!ram_we_no) begin
            we_lows <= we_lows + 1;
            we_addr <= ram_addr_o;
            we_data <= ram_data_o;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        cyc();
        pre_en   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (spi_done_o) begin
                ok = 1'b1;
                return;
            end
            cyc();
        end
        ok = spi_done_o;
    endtask

    task automatic request(input logic [16:0] a, input logic [7:0] d, input logic rw_n);
        spi_addr  = a;
        spi_wdata = d;
        spi_rw_n  = rw_n;
        spi_valid = 1'b1;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        n_cmp++;
        if ({spi_done_o, bus_req_o, ram_oe_no, ram_we_no, spi_data_o, ram_addr_o, ram_data_o}
            !== {1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 17'h0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_values: got done=%b req=%b oe_n=%b we_n=%b rd=%h addr=%h wd=%h, required 0 0 1 1 00 00000 00",
                     spi_done_o, bus_req_o, ram_oe_no, ram_we_no, spi_data_o, ram_addr_o, ram_data_o);
        end
`ifdef SPI_XFER_TIMEOUT_EN
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: got %b required 0", err_o);
        end
`endif
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_write();
        int   o0 = oe_lows;
        int   w0 = we_lows;
        int   slot_cyc;
        bit   ok;
        exp_t e;
        request(17'h1_0203, 8'hA5, 1'b0);
        sb.push_back('{addr: 17'h1_0203, data: 8'hA5, rw_n: 1'b0});
        cyc();
        n_cmp++;
        if (bus_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL write_bus_req: got %b required 1", bus_req_o);
        end
        cyc();
        cyc();
        cyc();
        slot = 1'b1;
        slot_cyc = cyc_no;
        cyc();
        slot = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (!ok || (cyc_no - slot_cyc) != AC + 1) begin
            n_bad++;
            $display("FAIL write_done_latency: got ok=%0d latency=%0d required ok=1 latency=%0d",
                     ok, cyc_no - slot_cyc, AC + 1);
        end
        n_cmp++;
        if ((we_lows - w0) != 1 || (oe_lows - o0) != 0) begin
            n_bad++;
            $display("FAIL write_strobes: got we_low=%0d oe_low=%0d required 1 0", we_lows - w0, oe_lows - o0);
        end
        n_cmp++;
        if ({we_addr, we_data} !== {17'h1_0203, 8'hA5}) begin
            n_bad++;
            $display("FAIL write_bus_values: got addr=%h data=%h required 10203 a5", we_addr, we_data);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL write_sb: got empty scoreboard required one entry");
        end else begin
            e = sb.pop_front();
            if (mem[e.addr] !== e.data) begin
                n_bad++;
                $display("FAIL write_ram: got %h required %h", mem[e.addr], e.data);
            end
        end
        spi_valid = 1'b0;
        cyc();
        n_cmp++;
        if (spi_done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL write_done_fall: got %b required 0", spi_done_o);
        end
        cyc();
    endtask

    task automatic test_read();
        int   o0, w0, slot_cyc;
        bit   ok;
        exp_t e;
        preload(17'h0_8000, 8'h3C);
        o0 = oe_lows;
        w0 = we_lows;
        request(17'h0_8000, 8'h00, 1'b1);
        sb.push_back('{addr: 17'h0_8000, data: 8'h3C, rw_n: 1'b1});
        cyc();
        cyc();
        slot = 1'b1;
        slot_cyc = cyc_no;
        cyc();
        slot = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (!ok || (cyc_no - slot_cyc) != AC + 1) begin
            n_bad++;
            $display("FAIL read_done_latency: got ok=%0d latency=%0d required ok=1 latency=%0d",
                     ok, cyc_no - slot_cyc, AC + 1);
        end
        n_cmp++;
        if ((oe_lows - o0) != AC || (we_lows - w0) != 0) begin
            n_bad++;
            $display("FAIL read_strobes: got oe_low=%0d we_low=%0d required %0d 0", oe_lows - o0, we_lows - w0, AC);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL read_sb: got empty scoreboard required one entry");
        end else begin
            e = sb.pop_front();
            if (spi_data_o !== e.data) begin
                n_bad++;
                $display("FAIL read_data: got %h required %h", spi_data_o, e.data);
            end
        end
        cyc();
        n_cmp++;
        if ({spi_done_o, spi_data_o} !== {1'b1, 8'h3C}) begin
            n_bad++;
            $display("FAIL read_hold: got done=%b data=%h required 1 3c", spi_done_o, spi_data_o);
        end
        spi_valid = 1'b0;
        cyc();
        n_cmp++;
        if (spi_done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL read_done_fall: got %b required 0", spi_done_o);
        end
        cyc();
    endtask

    task automatic test_abort();
        int o0 = oe_lows;
        int w0 = we_lows;
        bit done_seen = 1'b0;
        request(17'h0_0055, 8'h77, 1'b0);
        cyc();
        cyc();
        spi_valid = 1'b0;
        cyc();
        slot = 1'b1;
        cyc();
        slot = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (spi_done_o) done_seen = 1'b1;
            cyc();
        end
        n_cmp++;
        if ((oe_lows - o0) != 0 || (we_lows - w0) != 0) begin
            n_bad++;
            $display("FAIL abort_strobes: got oe_low=%0d we_low=%0d required 0 0", oe_lows - o0, we_lows - w0);
        end
        n_cmp++;
        if ({done_seen, bus_req_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_state: got done_seen=%b req=%b required 0 0", done_seen, bus_req_o);
        end
    endtask

    task automatic test_valid_drop_mid_access();
        int   w0 = we_lows;
        bit   done_seen = 1'b0;
        exp_t e;
        request(17'h0_0123, 8'h5A, 1'b0);
        sb.push_back('{addr: 17'h0_0123, data: 8'h5A, rw_n: 1'b0});
        cyc();
        slot = 1'b1;
        cyc();
        slot = 1'b0;
        cyc();
        spi_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (spi_done_o) done_seen = 1'b1;
            cyc();
        end
        n_cmp++;
        if ({done_seen, bus_req_o, ram_we_no, ram_oe_no} !== 4'b0011) begin
            n_bad++;
            $display("FAIL drop_state: got done_seen=%b req=%b we_n=%b oe_n=%b required 0 0 1 1",
                     done_seen, bus_req_o, ram_we_no, ram_oe_no);
        end
        n_cmp++;
        if ((we_lows - w0) != 1) begin
            n_bad++;
            $display("FAIL drop_we_count: got %0d required 1", we_lows - w0);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL drop_sb: got empty scoreboard required one entry");
        end else begin
            e = sb.pop_front();
            if (mem[e.addr] !== e.data) begin
                n_bad++;
                $display("FAIL drop_ram: got %h required %h", mem[e.addr], e.data);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        preload(17'h0_0456, 8'h00);
        request(17'h0_0456, 8'hC3, 1'b0);
        cyc();
        slot = 1'b1;
        cyc();
        slot = 1'b0;
        cyc();
        n_cmp++;
        if (ram_we_no !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_precond_we: got %b required 0", ram_we_no);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ram_we_no, ram_oe_no, spi_done_o, bus_req_o} !== 4'b1100) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got we_n=%b oe_n=%b done=%b req=%b required 1 1 0 0",
                     ram_we_no, ram_oe_no, spi_done_o, bus_req_o);
        end
        spi_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        n_cmp++;
        if (mem[17'h0_0456] !== 8'h00) begin
            n_bad++;
            $display("FAIL rstmid_ram: got %h required 00", mem[17'h0_0456]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t reqs[3];
        exp_t e;
        int   slot_cyc;
        bit   ok;
        preload(17'h1_FFFF, 8'hE1);
        reqs[0] = '{addr: 17'h1_FFFF, data: 8'hE1, rw_n: 1'b1};
        reqs[1] = '{addr: 17'h0_0000, data: 8'h99, rw_n: 1'b0};
        reqs[2] = '{addr: 17'h0_0000, data: 8'h99, rw_n: 1'b1};
        for (int r = 0; r < 3; r++) begin
            request(reqs[r].addr, reqs[r].rw_n ? 8'h00 : reqs[r].data, reqs[r].rw_n);
            sb.push_back(reqs[r]);
            cyc();
            slot = 1'b1;
            slot_cyc = cyc_no;
            cyc();
            slot = 1'b0;
            wait_done(20, ok);
            n_cmp++;
            if (!ok || (cyc_no - slot_cyc) != AC + 1 || ram_addr_o !== reqs[r].addr) begin
                n_bad++;
                $display("FAIL b2b_done_%0d: got ok=%0d latency=%0d addr=%h required 1 %0d %h",
                         r, ok, cyc_no - slot_cyc, ram_addr_o, AC + 1, reqs[r].addr);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL b2b_sb_%0d: got empty scoreboard required one entry", r);
            end else begin
                e = sb.pop_front();
                if (e.rw_n && spi_data_o !== e.data) begin
                    n_bad++;
                    $display("FAIL b2b_read_%0d: got %h required %h", r, spi_data_o, e.data);
                end else if (!e.rw_n && mem[e.addr] !== e.data) begin
                    n_bad++;
                    $display("FAIL b2b_write_%0d: got %h required %h", r, mem[e.addr], e.data);
                end
            end
            spi_valid = 1'b0;
            cyc();
        end
        n_cmp++;
        if ({spi_done_o, bus_req_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_end: got done=%b req=%b required 0 0", spi_done_o, bus_req_o);
        end
        cyc();
    endtask

`ifdef SPI_XFER_TIMEOUT_EN
    task automatic test_timeout();
        int   o0 = oe_lows;
        int   w0 = we_lows;
        int   start;
        bit   ok;
        exp_t e;
        request(17'h0_0200, 8'h00, 1'b1);
        start = cyc_no;
        cyc();
        wait_done(40, ok);
        n_cmp++;
        if (!ok || (cyc_no - start) != TMO + 1) begin
            n_bad++;
            $display("FAIL tmo_latency: got ok=%0d cycles=%0d required 1 %0d", ok, cyc_no - start, TMO + 1);
        end
        n_cmp++;
        if ({err_o, spi_data_o, bus_req_o} !== {1'b1, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL tmo_outputs: got err=%b data=%h req=%b required 1 ff 0", err_o, spi_data_o, bus_req_o);
        end
        n_cmp++;
        if ((oe_lows - o0) != 0 || (we_lows - w0) != 0) begin
            n_bad++;
            $display("FAIL tmo_strobes: got oe_low=%0d we_low=%0d required 0 0", oe_lows - o0, we_lows - w0);
        end
        spi_valid = 1'b0;
        cyc();
        cyc();
        request(17'h0_8000, 8'h00, 1'b1);
        sb.push_back('{addr: 17'h0_8000, data: 8'h3C, rw_n: 1'b1});
        start = cyc_no;
        cyc();
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_err_clear: got %b required 0", err_o);
        end
        while (cyc_no - start < TMO) cyc();
        slot = 1'b1;
        cyc();
        slot = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL tmo_sb: got empty scoreboard required one entry");
        end else begin
            e = sb.pop_front();
            if ({ok, err_o, spi_data_o} !== {1'b1, 1'b0, e.data}) begin
                n_bad++;
                $display("FAIL tmo_slot_wins: got done=%b err=%b data=%h required 1 0 %h", ok, err_o, spi_data_o, e.data);
            end
        end
        spi_valid = 1'b0;
        cyc();
        cyc();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        spi_addr  = '0;
        spi_wdata = '0;
        spi_rw_n  = 1'b0;
        spi_valid = 1'b0;
        slot      = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_abort();
        test_valid_drop_mid_access();
        test_reset_mid_access();
        test_back_to_back();
`ifdef SPI_XFER_TIMEOUT_EN
        test_timeout();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
